// File: rtl/key_control_if.sv
// Bundle of the signals exchanged between the round-key sequencer and the
// encryption rounds block. The rounds side is the master: it issues the start
// and requests keys. key_control is the slave: it presents the keys.
interface key_control_if #(
   parameter int KEY_W    = 128,
   parameter int MAX_KEYS = 15
);
   logic                        enableKeyControl;
   logic [0:KEY_W*MAX_KEYS-1]   keyExp;
   logic [4:0]                  numRounds;
   logic                        keyReq;
   logic [KEY_W-1:0]            newKey;
   logic                        keyValid;
   logic [3:0]                  roundIdx;
   logic                        lastKey;
   logic                        keyControlDone;
   logic                        keyControlErr;

   modport master (
      output enableKeyControl, keyExp, numRounds, keyReq,
      input  newKey, keyValid, roundIdx, lastKey, keyControlDone, keyControlErr
   );

   modport slave (
      input  enableKeyControl, keyExp, numRounds, keyReq,
      output newKey, keyValid, roundIdx, lastKey, keyControlDone, keyControlErr
   );
endinterface

// File: rtl/key_control.sv
// Forward round-key sequencer: snapshots the expanded key on start and
// presents round keys 0..Nr-1 in ascending order, one per keyValid/keyReq
// handshake. Every output is a register.
// Optional feature macro: KEY_CONTROL_ROUNDS_CHECK_EN rejects a start whose
// numRounds is not 11, 13 or 15 with a one-cycle keyControlErr pulse.
module key_control #(
   parameter int KEY_W    = 128,
   parameter int MAX_KEYS = 15
) (
   input logic          clk,
   input logic          rst,
   key_control_if.slave bus
);
   localparam int EXP_W = KEY_W * MAX_KEYS;

   typedef enum logic [1:0] {IDLE, PRESENT, DONE} state_t;

   state_t             state, state_n;
   logic [0:EXP_W-1]   key_q;
   logic               load;
   logic [3:0]         idx, idx_n;
   logic [3:0]         count, count_n;
   logic [3:0]         idx_inc, idx_last;
   logic [KEY_W-1:0]   new_key_n;
   logic               valid_n, last_n, done_n, err_n;
   logic [3:0]         ridx_n;
   logic               err_pend, err_pend_n;

   // Round key i sits at bits [KEY_W*i : KEY_W*i+KEY_W-1] of the snapshot.
   function automatic logic [KEY_W-1:0] select_key(input logic [0:EXP_W-1] k,
                                                   input logic [3:0] i);
      logic [KEY_W-1:0] r;
      r = '0;
      for (int j = 0; j < MAX_KEYS; j++) begin
         if (i == 4'(j)) r = k[KEY_W*j +: KEY_W];
      end
      return r;
   endfunction

   // 15 and 13 are taken literally; anything else falls back to AES-128.
   function automatic logic [3:0] map_rounds(input logic [4:0] n);
      case (n)
         5'd15:   return 4'd15;
         5'd13:   return 4'd13;
         default: return 4'd11;
      endcase
   endfunction

   function automatic logic rounds_legal(input logic [4:0] n);
      return (n == 5'd11) || (n == 5'd13) || (n == 5'd15);
   endfunction

   assign idx_inc  = idx + 4'd1;
   assign idx_last = count - 4'd1;

   // Next-state and next-output logic; outputs are registered below.
   always_comb begin
      state_n    = state;
      idx_n      = idx;
      count_n    = count;
      load       = 1'b0;
      new_key_n  = bus.newKey;
      valid_n    = bus.keyValid;
      ridx_n     = bus.roundIdx;
      last_n     = bus.lastKey;
      done_n     = 1'b0;
      err_pend_n = 1'b0;
      err_n      = err_pend;
      case (state)
         IDLE: begin
            new_key_n = '0;
            valid_n   = 1'b0;
            ridx_n    = 4'd0;
            last_n    = 1'b0;
            idx_n     = 4'd0;
            if (bus.enableKeyControl) begin
`ifdef KEY_CONTROL_ROUNDS_CHECK_EN
               if (!rounds_legal(bus.numRounds)) begin
                  err_pend_n = 1'b1;
               end else begin
                  load    = 1'b1;
                  count_n = map_rounds(bus.numRounds);
                  state_n = PRESENT;
               end
`else
               load    = 1'b1;
               count_n = map_rounds(bus.numRounds);
               state_n = PRESENT;
`endif
            end
         end
         PRESENT: begin
            if (!bus.keyValid) begin
               // First cycle after the snapshot: raise key 0.
               valid_n   = 1'b1;
               new_key_n = select_key(key_q, idx);
               ridx_n    = idx;
               last_n    = (idx == idx_last);
            end else if (bus.keyReq) begin
               if (idx == idx_last) begin
                  state_n   = DONE;
                  valid_n   = 1'b0;
                  new_key_n = '0;
                  ridx_n    = 4'd0;
                  last_n    = 1'b0;
                  done_n    = 1'b1;
               end else begin
                  idx_n     = idx_inc;
                  new_key_n = select_key(key_q, idx_inc);
                  ridx_n    = idx_inc;
                  last_n    = (idx_inc == idx_last);
               end
            end
         end
         DONE: begin
            state_n = IDLE;
            idx_n   = 4'd0;
         end
         default: state_n = IDLE;
      endcase
   end

   // State, counters and output registers; reset aborts any sequence.
   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= IDLE;
         idx                <= 4'd0;
         count              <= 4'd0;
         err_pend           <= 1'b0;
         bus.newKey         <= '0;
         bus.keyValid       <= 1'b0;
         bus.roundIdx       <= 4'd0;
         bus.lastKey        <= 1'b0;
         bus.keyControlDone <= 1'b0;
         bus.keyControlErr  <= 1'b0;
      end else begin
         state              <= state_n;
         idx                <= idx_n;
         count              <= count_n;
         err_pend           <= err_pend_n;
         bus.newKey         <= new_key_n;
         bus.keyValid       <= valid_n;
         bus.roundIdx       <= ridx_n;
         bus.lastKey        <= last_n;
         bus.keyControlDone <= done_n;
         bus.keyControlErr  <= err_n;
      end
   end

   // Expanded-key snapshot taken on an accepted start.
   always_ff @(posedge clk) begin
      if (load) key_q <= bus.keyExp;
   end
endmodule
